// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM pipeline stage controller.
package mem_stage_ctrl_pkg;

    // Access FSM: IDLE handles pass-through and zero-wait ops; ACCESS covers wait states.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Byte address that maps onto data-memory word 0.
    localparam int DEFAULT_ADDR_BASE = 1024;

    // Wait counter width; supports up to 15 wait cycles.
    localparam int CNT_W = 4;

endpackage : mem_stage_ctrl_pkg

// File: rtl/mem_wait_counter.sv
// Wait-state counter for data-memory accesses: clear, enable and a terminal flag.
module mem_wait_counter
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TERMINAL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign term_o  = (cnt_q == CNT_W'(TERMINAL));

endmodule : mem_wait_counter

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: address translation, wait-state sequencing,
// pipeline freeze generation and the MEM/WB pipeline register.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        dst_in,
    input  logic [31:0]       alu_res_in,
    input  logic [31:0]       val_rm_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              freeze,
    output logic [3:0]        dst_out,
    output logic [31:0]       alu_res_out,
    output logic [31:0]       mem_data_out,
    output logic              mem_read_out,
    output logic              wb_en_out
);

    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_CYCLES);

    mem_state_t       state_q;
    mem_state_t       state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_term;
    logic             cnt_en;
    logic             cnt_clr;
    logic             strobe;
    logic             freeze_c;
    logic             capture;
    logic             mem_op;

    logic [3:0]       dst_q;
    logic [31:0]      alu_res_q;
    logic [31:0]      mem_data_q;
    logic             mem_read_q;
    logic             wb_en_q;

    // A simultaneous read and write request is treated as a read.
    assign mem_op = mem_read_in | mem_write_in;

    // Word address relative to the memory window; wraps, no range check.
    assign mem_addr  = ADDR_W'((alu_res_in - 32'(ADDR_BASE)) >> 2);
    assign mem_wdata = val_rm_in;

    mem_wait_counter #(
        .TERMINAL (WAIT_CYCLES)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt),
        .term_o  (cnt_term)
    );

    // Next-state and control decode for the access FSM.
    always_comb begin
        state_d  = state_q;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        strobe   = 1'b0;
        freeze_c = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    strobe = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        capture = 1'b1;
                    end else begin
                        freeze_c = 1'b1;
                        cnt_en   = 1'b1;
                        state_d  = ACCESS;
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                strobe = 1'b1;
                if (cnt_term) begin
                    capture = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    freeze_c = (cnt != WAIT_C);
                    cnt_en   = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Strobes and freeze are forced low while reset is held.
    assign freeze = freeze_c & ~rst;
    assign mem_re = strobe & mem_read_in & ~rst;
    assign mem_we = strobe & mem_write_in & ~mem_read_in & ~rst;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB register: bubble while frozen, capture on completion or pass-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q      <= '0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            mem_read_q <= 1'b0;
            wb_en_q    <= 1'b0;
        end else if (freeze_c) begin
            mem_read_q <= 1'b0;
            wb_en_q    <= 1'b0;
        end else if (capture) begin
            dst_q      <= dst_in;
            alu_res_q  <= alu_res_in;
            mem_read_q <= mem_read_in;
            wb_en_q    <= wb_en_in;
            if (mem_read_in) begin
                mem_data_q <= mem_rdata;
            end
        end
    end

    assign dst_out      = dst_q;
    assign alu_res_out  = alu_res_q;
    assign mem_data_out = mem_data_q;
    assign mem_read_out = mem_read_q;
    assign wb_en_out    = wb_en_q;

endmodule : mem_stage_ctrl

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, means the number of wait cycles per data-memory access (0 to 15).
REQ-002 Parameter ADDR_BASE, default 1024, means the byte address mapped to data-memory word 0.
REQ-003 Parameter ADDR_W, default 16, means the data-memory word-address width.
REQ-004 Ports (name, direction, width, meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  synchronous, active-high reset
 dst_in  in  4  destination register from EXE/MEM latch
 alu_res_in  in  32  ALU result; byte address for memory ops
 val_rm_in  in  32  store data
 mem_read_in  in  1  load request
 mem_write_in  in  1  store request
 wb_en_in  in  1  writeback enable
 mem_addr  out  ADDR_W  data-memory word address
 mem_wdata  out  32  data-memory write data
 mem_we  out  1  data-memory write strobe
 mem_re  out  1  data-memory read strobe
 mem_rdata  in  32  data-memory read data, valid WAIT_CYCLES cycles after mem_re rises
 freeze  out  1  stall request to upstream stages
 dst_out  out  4  MEM/WB destination register
 alu_res_out  out  32  MEM/WB ALU result
 mem_data_out  out  32  MEM/WB load data
 mem_read_out  out  1  MEM/WB load flag
 wb_en_out  out  1  MEM/WB writeback enable

Function
REQ-005 The FSM SHALL have two states: IDLE and ACCESS.
REQ-006 mem_addr SHALL equal (alu_res_in - ADDR_BASE) >> 2, truncated to ADDR_W bits, with wrap-around and no range check.
REQ-007 mem_wdata SHALL equal val_rm_in combinationally.
REQ-008 In IDLE with no memory op, the MEM/WB outputs SHALL capture their inputs at the next edge (latency 1) and freeze SHALL be 0.
REQ-009 In IDLE with a memory op and WAIT_CYCLES>0, the block SHALL assert freeze, assert the strobe combinationally, go to ACCESS and set cnt=1.
REQ-010 In ACCESS the strobe SHALL stay asserted and cnt SHALL increment each cycle.
REQ-011 In ACCESS, freeze SHALL be 1 while cnt<WAIT_CYCLES; when cnt==WAIT_CYCLES, freeze SHALL be 0, the strobe stays high, the MEM/WB outputs capture with mem_data_out=mem_rdata, and the next state is IDLE.
REQ-012 Each memory op SHALL occupy WAIT_CYCLES+1 cycles, with freeze high for exactly the first WAIT_CYCLES of them.
REQ-013 If WAIT_CYCLES==0, an op SHALL complete in IDLE in one cycle with freeze never asserted.
REQ-014 At every edge where freeze=1, the block SHALL capture a bubble: wb_en_out=0 and mem_read_out=0, with the other MEM/WB outputs holding.
REQ-015 Inputs SHALL be sampled every cycle; upstream guarantees they are stable while freeze=1.
REQ-016 If mem_read_in and mem_write_in are both 1, the op SHALL be a read and mem_we SHALL stay 0.
REQ-017 mem_data_out SHALL hold its value on non-load completions.
REQ-018 On a store completion, wb_en_out SHALL equal wb_en_in, passed through unmodified.
REQ-019 A new op presented on the cycle after completion SHALL start immediately, with no idle gap.

Reset
REQ-020 When rst=1 at an edge, the block SHALL enter IDLE with cnt=0 and every registered output 0, including all MEM/WB outputs.
REQ-021 While rst=1, mem_we, mem_re and freeze SHALL be 0.
REQ-022 A reset during ACCESS SHALL abort the access, and the aborted load SHALL never reach MEM/WB.

Structure
REQ-023 A shared package SHALL hold the state typedef {IDLE, ACCESS}, the default ADDR_BASE and the counter width (4 bits).
REQ-024 The wait counter SHALL be a sub-module named mem_wait_counter (clear, enable, count, terminal flag); the FSM and MEM/WB register stay in mem_stage_ctrl.

Verification
REQ-025 Non-memory op (alu_res_in=0x55, dst_in=3, wb_en_in=1, WAIT_CYCLES=3) -> next cycle dst_out=3, alu_res_out=0x55, wb_en_out=1; freeze stays 0.
REQ-026 Load at alu_res_in=1032 (WAIT_CYCLES=3, mem_rdata=0xDEADBEEF on cycle 4) -> mem_addr=2, mem_re high for 4 cycles, freeze high for 3, then mem_data_out=0xDEADBEEF and mem_read_out=1.
REQ-027 Store at 1028 with val_rm_in=0x12345678 -> mem_addr=1, mem_we high for 4 cycles, mem_wdata=0x12345678, wb_en_out=0 during freeze.
REQ-028 Reset on cycle 2 of a load -> next cycle mem_re=0, freeze=0, all outputs 0, state IDLE.
REQ-029 WAIT_CYCLES=0 with back-to-back load then store -> each completes in 1 cycle and freeze is never 1.
REQ-030 mem_read_in=mem_write_in=1 -> mem_we=0, read performed; alu_res_in=1020 -> mem_addr=0xFFFF.
